// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM access controller.
// The S_BIST state exists only when SRAM_CTRL_BIST_EN is defined.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] BIST_SEED = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD1,
    S_RD2
`ifdef SRAM_CTRL_BIST_EN
    ,
    S_BIST
`endif
  } state_e;

endpackage

// File: rtl/sram_ctrl_bist.sv
// Self-test sequencer: address counter, phase flag, pattern and compare.
// Instantiated by sram_ctrl only when SRAM_CTRL_BIST_EN is defined.
module sram_ctrl_bist
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              active_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              last_o,
  output logic              fail_o
);

  logic              active_q, active_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fail_q, fail_d;
  logic [DATA_W-1:0] pat;

  assign pat      = DATA_W'(BIST_SEED) ^ DATA_W'(addr_q);
  assign active_o = active_q;
  assign we_o     = !rd_q;
  assign addr_o   = addr_q;
  assign wdata_o  = pat;
  assign last_o   = rd_q && (&addr_q);
  assign fail_o   = fail_q;

  // step_i marks the end of one WR or RD2 cycle issued for self-test
  always_comb begin
    active_d = active_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    fail_d   = fail_q;
    if (start_i) begin
      active_d = 1'b1;
      rd_d     = 1'b0;
      addr_d   = '0;
      fail_d   = 1'b0;
    end else if (step_i) begin
      addr_d = addr_q + 1'b1;
      if (rd_q) begin
        if (dout_i != pat) begin
          fail_d = 1'b1;
        end
        if (&addr_q) begin
          active_d = 1'b0;
          rd_d     = 1'b0;
        end
      end else if (&addr_q) begin
        rd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      fail_q   <= fail_d;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready to 6T SRAM cycle sequencer with registered pin drivers.
// Optional self-test is compiled in with SRAM_CTRL_BIST_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              en,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ysw,
  output logic              ysr,
  output logic [ADDR_W-1:0] add,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  input  logic              bist_start,
  output logic              bist_done,
  output logic              bist_fail
);

  state_e            state_q, state_d;
  logic              ysw_q, ysw_d;
  logic              ysr_q, ysr_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef SRAM_CTRL_BIST_EN
  logic              done_q, done_d;
  logic              bist_go;
  logic              bist_step;
  logic              bist_act;
  logic              bist_we;
  logic              bist_last;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_wdata;

  sram_ctrl_bist #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bist (
    .clk      (en),
    .rst      (rst),
    .start_i  (bist_go),
    .step_i   (bist_step),
    .dout_i   (dout),
    .active_o (bist_act),
    .we_o     (bist_we),
    .addr_o   (bist_addr),
    .wdata_o  (bist_wdata),
    .last_o   (bist_last),
    .fail_o   (bist_fail)
  );

  assign bist_done = done_q;
`else
  logic unused_bist;

  assign unused_bist = bist_start;
  assign bist_done   = 1'b0;
  assign bist_fail   = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ysw       = ysw_q;
  assign ysr       = ysr_q;
  assign add       = add_q;
  assign din       = din_q;

  // Selects and bus default low so add/din read 0 whenever idle
  always_comb begin
    state_d     = state_q;
    ysw_d       = 1'b0;
    ysr_d       = 1'b0;
    add_d       = '0;
    din_d       = '0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
`ifdef SRAM_CTRL_BIST_EN
    done_d      = 1'b0;
    bist_go     = 1'b0;
    bist_step   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef SRAM_CTRL_BIST_EN
        if (bist_start) begin
          bist_go = 1'b1;
          state_d = S_BIST;
        end else
`endif
        if (req_valid) begin
          add_d = req_addr;
          if (req_we) begin
            state_d = S_WR;
            ysw_d   = 1'b1;
            din_d   = req_wdata;
          end else begin
            state_d = S_RD1;
            ysr_d   = 1'b1;
          end
        end
      end
      S_WR: begin
        state_d = S_IDLE;
`ifdef SRAM_CTRL_BIST_EN
        if (bist_act) begin
          bist_step = 1'b1;
          state_d   = S_BIST;
        end
`endif
      end
      S_RD1: begin
        state_d = S_RD2;
        ysr_d   = 1'b1;
        add_d   = add_q;
      end
      S_RD2: begin
        state_d = S_IDLE;
`ifdef SRAM_CTRL_BIST_EN
        if (bist_act) begin
          bist_step = 1'b1;
          done_d    = bist_last;
          state_d   = bist_last ? S_IDLE : S_BIST;
        end else
`endif
        begin
          rsp_valid_d = 1'b1;
          rdata_d     = dout;
        end
      end
`ifdef SRAM_CTRL_BIST_EN
      S_BIST: begin
        add_d = bist_addr;
        if (bist_we) begin
          state_d = S_WR;
          ysw_d   = 1'b1;
          din_d   = bist_wdata;
        end else begin
          state_d = S_RD1;
          ysr_d   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge en) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ysw_q       <= 1'b0;
      ysr_q       <= 1'b0;
      add_q       <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef SRAM_CTRL_BIST_EN
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ysw_q       <= ysw_d;
      ysr_q       <= ysr_d;
      add_q       <= add_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
`ifdef SRAM_CTRL_BIST_EN
      done_q      <= done_d;
`endif
    end
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Host-side access controller that drives the 8-word × 8-bit 6T SRAM macro's `ysw`/`ysr`/`add`/`din` pins and captures `dout`. It converts a valid/ready request port into correctly sequenced, glitch-free SRAM cycles. It guarantees `ysw` and `ysr` are never high together. It is the initiator for the `sram` macro and replaces hand-driven testbench stimulus in the integrated design.

## Interface
- `ADDR_W`, 3: SRAM address width; depth is 2^ADDR_W.
- `DATA_W`, 8: SRAM word width.

- `en` input 1: clock. Same net as the SRAM `en`; rising-edge active.
- `rst` input 1: reset. Synchronous, active-high.
- `req_valid` input 1: host request present.
- `req_ready` output 1: controller can accept a request this cycle.
- `req_we` input 1: 1 means write, 0 means read.
- `req_addr` input ADDR_W: word address.
- `req_wdata` input DATA_W: write data.
- `rsp_valid` output 1: one-cycle pulse; read data valid.
- `rsp_rdata` output DATA_W: captured read data; held until the next read completes.
- `ysw` output 1: SRAM write select.
- `ysr` output 1: SRAM read select.
- `add` output ADDR_W: SRAM address.
- `din` output DATA_W: SRAM write data.
- `dout` input DATA_W: SRAM read data.
- `bist_start` input 1: self-test start pulse (see Configuration).
- `bist_done` output 1: one-cycle pulse when self-test ends.
- `bist_fail` output 1: sticky self-test mismatch flag.

## Operation
- States: IDLE, WR, RD1, RD2, and BIST (only when compiled in).
- IDLE behaviour:
  - `req_ready`=1 in IDLE, except in the cycle `rst` is high.
  - A request is accepted on a rising edge where `req_valid && req_ready`.
  - Address and data are registered on acceptance.
- Write: IDLE→WR. In WR, `ysw`=1 and `add`/`din` carry the registered request for exactly one cycle. Then WR→IDLE.
- Read: IDLE→RD1→RD2→IDLE.
  - `ysr`=1 and `add` are held through RD1 and RD2.
  - `dout` is registered into `rsp_rdata` at the end of RD2.
- All SRAM-side outputs are registered. `add`/`din` are 0 whenever the corresponding select is low; they never float.
- `ysw && ysr` is never 1.
- `req_ready`=0 in WR, RD1, RD2 and BIST.
- There is no response back-pressure. A new request may be accepted in the cycle `rsp_valid` is high.
- Address wrap is not applicable: all 2^ADDR_W addresses are valid.

## Timing
- Reset values: `ysw`=0, `ysr`=0, `add`=0, `din`=0, `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=0, `bist_done`=0, `bist_fail`=0.
- `req_ready` rises in the first cycle after `rst` deasserts.
- Write: accepted at edge E0; `ysw`=1 between E0 and E1; SRAM writes at E1; `req_ready`=1 after E1. Throughput is one write per 2 cycles.
- Read: accepted at E0; `ysr`=1 between E0 and E2; `dout` captured at E2; `rsp_valid`=1 between E2 and E3. Latency is 2 cycles; throughput is one read per 3 cycles.
- Reset mid-access: all state is abandoned at the reset edge and no `rsp_valid` is issued. A write whose `ysw` was already high at that edge completes in the SRAM.
- `bist_start` while not in IDLE is ignored. When `req_valid` and `bist_start` coincide in IDLE, `bist_start` wins.

## Configuration
- Macro: `SRAM_CTRL_BIST_EN`.
- Defined:
  - `bist_start` in IDLE enters BIST.
  - Write phase: writes word k = 8'hA5 ^ k to every address k=0..7, 2 cycles each.
  - Read phase: reads every address back, 3 cycles each, and compares.
  - On any mismatch, `bist_fail` goes to 1 and stays sticky until the next `bist_start` or `rst`.
  - `bist_done` pulses in the cycle BIST→IDLE. `rsp_valid` stays 0 throughout BIST.
  - Total BIST duration is 8×2 + 8×3 = 40 cycles.
- Undefined: `bist_start` is ignored, `bist_done`=`bist_fail`=0 constantly, and the BIST state and logic are absent. All ports exist in both builds.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum;
  - default `ADDR_W`/`DATA_W` constants;
  - `BIST_SEED`=8'hA5.
- Sub-module `sram_ctrl_bist` contains the BIST address counter, phase flag, pattern generator and comparator. It is instantiated only under `SRAM_CTRL_BIST_EN` and requests SRAM cycles through the same WR/RD sequencer.

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0; `req_ready`=1 on the first cycle after release.
- Write addresses 0–3 with 8'h97, 8'hF9, 8'h81, 8'h99 → each has exactly one `ysw` cycle with the correct `add`/`din`, and `ysr`=0 throughout.
- Read addresses 0–3 back → `rsp_valid` 2 cycles after each accept, `rsp_rdata` = 8'h97, 8'hF9, 8'h81, 8'h99 respectively.
- Back-to-back: `req_valid` held high with alternating write/read to address 7 → `req_ready` gaps of exactly 1 cycle (write) and 2 cycles (read); `ysw`&`ysr` never both 1.
- Reset asserted during RD1 → no `rsp_valid`, `ysr`=0 the next cycle, IDLE after release.
- BIST (macro defined) → `bist_done` 40 cycles after start with `bist_fail`=0. With one SRAM bit forced stuck → `bist_fail`=1 and it stays 1 until the next `bist_start`.
